// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master
// native memory bus arbiter.
package mem_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF =
    32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef logic owner_t;
endpackage

// File: rtl/mem_bus_watchdog.sv
// Busy-cycle counter that flags the terminal cycle
// of a hung transfer; disabled when TIMEOUT_CYCLES=0.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic busy_i,
  input  logic s_ready_i,
  output logic fire_o
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on grant, count stalled busy cycles, saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (busy_i && !s_ready_i &&
                 cnt_q != SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign fire_o = (TIMEOUT_CYCLES != 0) && busy_i &&
                  (cnt_q == TERM);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the core and a loader
// onto one native-protocol slave, with a watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA =
    ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant_id,
  output logic              bus_error
);
  state_e state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_q, last_d;

  logic busy, own_valid, grant;
  logic wd_fire, tmo, done, fin;
  logic [DATA_W-1:0] rsel;

  assign busy      = (state_q == BUSY);
  assign own_valid = owner_q ? m1_valid : m0_valid;
  assign grant     = !busy && (m0_valid || m1_valid);

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (grant),
    .busy_i   (busy),
    .s_ready_i(s_ready),
    .fire_o   (wd_fire)
  );

  // A real completion in the terminal cycle beats the timeout.
  assign tmo  = busy && own_valid && wd_fire && !s_ready;
  assign done = s_valid && s_ready;
  assign fin  = done || tmo;

  // Slave request mux; zero while idle.
  always_comb begin
    s_valid = busy && own_valid && !tmo;
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (busy) begin
      if (owner_q) begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end else begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
    end
  end

  // Response routing: only the owner sees ready/data.
  always_comb begin
    rsel     = tmo ? ERR_RDATA : s_rdata;
    m0_ready = fin && !owner_q;
    m1_ready = fin && owner_q;
    m0_rdata = m0_ready ? rsel : '0;
    m1_rdata = m1_ready ? rsel : '0;
  end

  assign bus_error = tmo;
  assign grant_id  = owner_q;

  // Grant / release state machine.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          if (m0_valid && m1_valid) owner_d = !last_q;
          else                      owner_d = m1_valid;
        end
      end
      BUSY: begin
        if (fin || !own_valid) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; m0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter
// (TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0] m0_wstrb;
  logic m0_ready;
  logic [31:0] m0_rdata;
  logic m1_valid;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0] m1_wstrb;
  logic m1_ready;
  logic [31:0] m1_rdata;
  logic s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic s_ready;
  logic [31:0] s_rdata;
  logic grant_id, bus_error;

  typedef struct {
    logic        owner;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready),
    .s_rdata(s_rdata),
    .grant_id(grant_id), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic o, input logic [31:0] rd,
                      input logic e, input int c);
    exp_t x;
    x.owner = o; x.rd = rd; x.err = e; x.cyc = c;
    sb.push_back(x);
  endtask

  // Slave model + scoreboard pop for one transfer.
  task automatic wait_done(input int lat,
                           input logic [31:0] rd,
                           input bit drop);
    int seen, k;
    bit started, got;
    logic own;
    exp_t e;
    seen = 0; k = 0; started = 0; got = 0; own = 0;
    while (!got && k < 40) begin
      if (s_valid) started = 1;
      if (started && seen == lat) begin
        s_ready = 1'b1;
        s_rdata = rd;
      end
      #1;
      if (m0_ready || m1_ready) begin
        got = 1;
        own = m1_ready;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("owner", {31'd0, own}, {31'd0, e.owner});
          chk("rdata", own ? m1_rdata : m0_rdata, e.rd);
          chk("nonowner_rdata",
              own ? m0_rdata : m1_rdata, 32'd0);
          chk("both_ready", {31'd0, m0_ready & m1_ready},
              32'd0);
          chk("bus_error", {31'd0, bus_error},
              {31'd0, e.err});
          chk("grant_id", {31'd0, grant_id},
              {31'd0, e.owner});
          chk("done_cycle", 32'(seen), 32'(e.cyc));
        end
      end
      if (started) seen++;
      tick();
      s_ready = 1'b0;
      s_rdata = '0;
      k++;
    end
    if (!got) chk("done_budget", 32'd0, 32'd1);
    if (got && drop) begin
      if (own) m1_valid = 1'b0;
      else     m0_valid = 1'b0;
    end
  endtask

  initial begin
    resetn = 0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0;
    m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    tick(); tick();
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    resetn = 1;
    tick();

    // m0 read, slave ready 3 cycles after s_valid
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0;
    push(0, 32'h1234_5678, 0, 3);
    #1 chk("t1_lat0", {31'd0, s_valid}, 32'd0);
    tick();
    chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
    chk("t1_s_addr", s_addr, 32'h0000_0100);
    wait_done(3, 32'h1234_5678, 1);
    #1 chk("t1_idle", {31'd0, s_valid}, 32'd0);

    // both masters continuously valid
    resetn = 0; #1; resetn = 1;
    m0_valid = 1; m0_addr = 32'h0000_00A0;
    m1_valid = 1; m1_addr = 32'h0000_00B0;
    push(0, 32'h0000_0A01, 0, 0);
    push(1, 32'h0000_0B01, 0, 0);
    push(0, 32'h0000_0A02, 0, 0);
    push(1, 32'h0000_0B02, 0, 0);
    wait_done(0, 32'h0000_0A01, 0);
    #1 chk("t2_gap0", {31'd0, s_valid}, 32'd0);
    wait_done(0, 32'h0000_0B01, 0);
    #1 chk("t2_gap1", {31'd0, s_valid}, 32'd0);
    wait_done(0, 32'h0000_0A02, 0);
    #1 chk("t2_gap2", {31'd0, s_valid}, 32'd0);
    wait_done(0, 32'h0000_0B02, 0);
    m0_valid = 0; m1_valid = 0;
    #1 chk("t2_gap3", {31'd0, s_valid}, 32'd0);
    tick();

    // m1 write with m0 arriving and waiting
    m1_valid = 1; m1_addr = 32'h0000_2000;
    m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    tick();
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0300;
    #1;
    chk("t3_s_addr", s_addr, 32'h0000_2000);
    chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
    chk("t3_s_wstrb", {28'd0, s_wstrb}, 32'h3);
    chk("t3_s_instr", {31'd0, s_instr}, 32'd0);
    chk("t3_m0_wait", {31'd0, m0_ready}, 32'd0);
    chk("t3_grant", {31'd0, grant_id}, 32'd1);
    push(1, 32'h0000_0000, 0, 1);
    wait_done(1, 32'h0000_0000, 1);
    push(0, 32'h3333_0000, 0, 0);
    wait_done(0, 32'h3333_0000, 1);
    m0_instr = 0;

    // watchdog: slave never ready on m0 read
    m0_valid = 1; m0_addr = 32'h0000_0400;
    push(0, 32'hDEAD_BEEF, 1, 7);
    wait_done(-1, 32'h0, 1);
    #1;
    chk("t4_err_clear", {31'd0, bus_error}, 32'd0);
    chk("t4_idle", {31'd0, s_valid}, 32'd0);
    m1_valid = 1; m1_addr = 32'h0000_0500;
    push(1, 32'h3344_5566, 0, 0);
    wait_done(0, 32'h3344_5566, 1);

    // s_ready coinciding with terminal cycle
    m0_valid = 1; m0_addr = 32'h0000_0600;
    push(0, 32'h5A5A_5A5A, 0, 7);
    wait_done(7, 32'h5A5A_5A5A, 1);

    // reset while BUSY
    m1_valid = 1; m1_addr = 32'h0000_0700;
    tick();
    chk("t6_busy", {31'd0, s_valid}, 32'd1);
    resetn = 0;
    #1;
    chk("t6_s_valid_async", {31'd0, s_valid}, 32'd0);
    chk("t6_m1_ready", {31'd0, m1_ready}, 32'd0);
    tick();
    chk("t6_no_ready", {31'd0, m0_ready | m1_ready}, 32'd0);
    chk("t6_grant_rst", {31'd0, grant_id}, 32'd0);
    m0_valid = 1; m0_addr = 32'h0000_0800;
    resetn = 1;
    push(0, 32'h0808_0808, 0, 0);
    push(1, 32'h0707_0707, 0, 0);
    wait_done(0, 32'h0808_0808, 1);
    wait_done(0, 32'h0707_0707, 1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
